// File: rtl/apb_timer_sequencer.sv
// APB master that programs the APB timer (RELOAD, VALUE, CNTRL), polls INT and reports expiries.
// Define TIMER_SEQ_PERIODIC_EN to re-arm VALUE after each expiry; otherwise each run is one-shot.
module apb_timer_sequencer #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] TIMER_BASE = ADDR_WIDTH'(32'h0),
   parameter int unsigned           POLL_GAP   = 4
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    start,
   input  logic                    abort,
   input  logic [DATA_WIDTH-1:0]   cfg_reload,
   input  logic [DATA_WIDTH-1:0]   cfg_value,
   input  logic                    cfg_int_en,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic                    irq,
   output logic [15:0]             expire_cnt,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic                    PREADY,
   input  logic [DATA_WIDTH-1:0]   PRDATA
);

   localparam int unsigned           SW          = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_CNTRL  = TIMER_BASE + ADDR_WIDTH'(32'h0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_VALUE  = TIMER_BASE + ADDR_WIDTH'(32'h4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RELOAD = TIMER_BASE + ADDR_WIDTH'(32'h8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INT    = TIMER_BASE + ADDR_WIDTH'(32'hC);
   localparam logic [7:0]            GAP_LOAD    = 8'(POLL_GAP - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_RELOAD = 3'd1,
      S_WR_VALUE  = 3'd2,
      S_WR_CTRL   = 3'd3,
      S_POLL_RD   = 3'd4,
      S_POLL_GAP  = 3'd5,
      S_WR_STOP   = 3'd6,
      S_END       = 3'd7
   } state_t;

   state_t                  state_q, state_d;
   logic                    rearm_q, rearm_d;
   logic                    abort_q;
   logic [7:0]              gap_q;
   logic [DATA_WIDTH-1:0]   cfg_reload_q, cfg_value_q;
   logic                    cfg_int_en_q;
   logic                    busy_q, done_q, aborted_q, irq_q;
   logic [15:0]             expire_cnt_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    psel_q, penable_q, pwrite_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [SW-1:0]           pstrb_q;

   logic                    xfer_done_s, abort_eff_s, expiry_s, launch_s;
   logic [DATA_WIDTH-1:0]   reload_src_s, wdata_s;
   logic                    unused_prdata_s;

   assign unused_prdata_s = ^PRDATA[DATA_WIDTH-1:1];

   function automatic logic is_xfer(input state_t s);
      case (s)
         S_WR_RELOAD, S_WR_VALUE, S_WR_CTRL, S_POLL_RD, S_WR_STOP: is_xfer = 1'b1;
         default:                                                  is_xfer = 1'b0;
      endcase
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] xfer_addr(input state_t s);
      case (s)
         S_WR_RELOAD: xfer_addr = ADDR_RELOAD;
         S_WR_VALUE:  xfer_addr = ADDR_VALUE;
         S_POLL_RD:   xfer_addr = ADDR_INT;
         default:     xfer_addr = ADDR_CNTRL;
      endcase
   endfunction

   // Next-state decode, plus the bus fields for a transfer launched on this edge
   always_comb begin
      xfer_done_s  = psel_q & penable_q & PREADY;
      abort_eff_s  = abort_q | abort;
      expiry_s     = (state_q == S_POLL_RD) & xfer_done_s & PRDATA[0];
      state_d      = state_q;
      rearm_d      = rearm_q;
      case (state_q)
         S_IDLE: begin
            rearm_d = 1'b0;
            if (start && !abort) state_d = S_WR_RELOAD;
            else                 state_d = S_IDLE;
         end
         S_WR_RELOAD: begin
            if (!xfer_done_s)     state_d = S_WR_RELOAD;
            else if (abort_eff_s) state_d = S_WR_STOP;
            else                  state_d = S_WR_VALUE;
         end
         S_WR_VALUE: begin
            if (!xfer_done_s)     state_d = S_WR_VALUE;
            else if (abort_eff_s) state_d = S_WR_STOP;
            else if (rearm_q)     state_d = S_POLL_RD;
            else                  state_d = S_WR_CTRL;
         end
         S_WR_CTRL: begin
            if (!xfer_done_s)     state_d = S_WR_CTRL;
            else if (abort_eff_s) state_d = S_WR_STOP;
            else                  state_d = S_POLL_RD;
         end
         S_POLL_RD: begin
            if (!xfer_done_s)     state_d = S_POLL_RD;
            else if (abort_eff_s) state_d = S_WR_STOP;
            else if (PRDATA[0]) begin
`ifdef TIMER_SEQ_PERIODIC_EN
               state_d = S_WR_VALUE;
               rearm_d = 1'b1;
`else
               state_d = S_WR_STOP;
`endif
            end
            else                  state_d = S_POLL_GAP;
         end
         S_POLL_GAP: begin
            if (abort_eff_s)       state_d = S_WR_STOP;
            else if (gap_q == 8'd0) state_d = S_POLL_RD;
            else                   state_d = S_POLL_GAP;
         end
         S_WR_STOP: begin
            if (xfer_done_s) state_d = S_END;
            else             state_d = S_WR_STOP;
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      launch_s = is_xfer(state_d) && (state_d != state_q);
      // RELOAD is launched on the same edge that latches the configuration
      reload_src_s = (state_q == S_IDLE) ? cfg_reload : cfg_reload_q;
      case (state_d)
         S_WR_RELOAD: wdata_s = reload_src_s;
         S_WR_VALUE:  wdata_s = rearm_d ? cfg_reload_q : cfg_value_q;
         S_WR_CTRL:   wdata_s = DATA_WIDTH'({cfg_int_en_q, 3'b001});
         default:     wdata_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Sequencer state, status outputs and APB master outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= S_IDLE;
         rearm_q      <= 1'b0;
         abort_q      <= 1'b0;
         gap_q        <= 8'd0;
         cfg_reload_q <= {DATA_WIDTH{1'b0}};
         cfg_value_q  <= {DATA_WIDTH{1'b0}};
         cfg_int_en_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         irq_q        <= 1'b0;
         expire_cnt_q <= 16'd0;
         paddr_q      <= {ADDR_WIDTH{1'b0}};
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= {DATA_WIDTH{1'b0}};
         pstrb_q      <= {SW{1'b0}};
      end else begin
         state_q   <= state_d;
         rearm_q   <= rearm_d;
         busy_q    <= (state_d != S_IDLE);
         irq_q     <= expiry_s;
         done_q    <= (state_d == S_END) && !abort_eff_s;
         aborted_q <= (state_d == S_END) && abort_eff_s;

         if ((state_q == S_IDLE) || (state_q == S_END)) abort_q <= 1'b0;
         else if (abort)                                abort_q <= 1'b1;

         if ((state_q == S_IDLE) && (state_d == S_WR_RELOAD)) begin
            cfg_reload_q <= cfg_reload;
            cfg_value_q  <= cfg_value;
            cfg_int_en_q <= cfg_int_en;
            expire_cnt_q <= 16'd0;
         end else if (expiry_s && (expire_cnt_q != 16'hFFFF)) begin
            expire_cnt_q <= expire_cnt_q + 16'd1;
         end

         if ((state_d == S_POLL_GAP) && (state_q != S_POLL_GAP)) gap_q <= GAP_LOAD;
         else if ((state_q == S_POLL_GAP) && (gap_q != 8'd0))    gap_q <= gap_q - 8'd1;

         // A completing transfer may hand straight over to the next SETUP
         if (launch_s) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= xfer_addr(state_d);
            pwrite_q  <= (state_d != S_POLL_RD);
            pwdata_q  <= wdata_s;
            pstrb_q   <= (state_d != S_POLL_RD) ? {SW{1'b1}} : {SW{1'b0}};
         end else if (psel_q && !penable_q) begin
            penable_q <= 1'b1;
         end else if (xfer_done_s) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign irq        = irq_q;
   assign expire_cnt = expire_cnt_q;
   assign PADDR      = paddr_q;
   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PWDATA     = pwdata_q;
   assign PSTRB      = pstrb_q;

endmodule

// File: doc/apb_timer_sequencer.md
# apb_timer_sequencer

APB master controller that programs and supervises the APB timer slave on behalf of a simple local request interface. On `start` it writes the timer's RELOAD, VALUE and CNTRL registers, then polls the INT register until expiry. On expiry it raises `irq` and either stops the timer (one-shot) or re-arms it (periodic, compile option). It sits between a local control agent and the APB fabric, acting as the timer's only master.

## Interface
- `DATA_WIDTH`, 32: APB data width; `PSTRB` width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32: APB address width.
- `TIMER_BASE`, 32'h0: timer base address; register offsets are CNTRL +0x0, VALUE +0x4, RELOAD +0x8, INT +0xC.
- `POLL_GAP`, 4: idle cycles (`PSEL`=0) between consecutive INT polls; legal range 1..255.

Ports:
- `PCLK`, in, 1: single clock; all logic on its rising edge.
- `PRESET`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a timer run; honoured only in IDLE.
- `abort`, in, 1: stop the current run; honoured in any non-IDLE state.
- `cfg_reload`, in, DATA_WIDTH: RELOAD value, latched on accepted `start`.
- `cfg_value`, in, DATA_WIDTH: initial VALUE, latched on accepted `start`.
- `cfg_int_en`, in, 1: CNTRL bit 3 (INT_EN), latched on accepted `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a one-shot run completes normally.
- `aborted`, out, 1: one-cycle pulse when an aborted run returns to IDLE.
- `irq`, out, 1: one-cycle pulse per detected expiry.
- `expire_cnt`, out, 16: expiries since the last accepted `start`; saturates at 16'hFFFF.
- `PADDR`, out, ADDR_WIDTH: APB address.
- `PSEL`, out, 1: APB select.
- `PENABLE`, out, 1: APB enable.
- `PWRITE`, out, 1: APB write/read.
- `PWDATA`, out, DATA_WIDTH: APB write data.
- `PSTRB`, out, DATA_WIDTH/8: APB write strobes; all ones on writes, all zeros on reads.
- `PREADY`, in, 1: APB ready from the slave.
- `PRDATA`, in, DATA_WIDTH: APB read data.

## Operation
- FSM states: IDLE, WR_RELOAD, WR_VALUE, WR_CTRL, POLL_RD, POLL_GAP, WR_STOP, END.
- Each `WR_*` and POLL_RD state performs exactly one APB transfer:
  - SETUP cycle: `PSEL`=1, `PENABLE`=0.
  - ACCESS cycles: `PSEL`=1, `PENABLE`=1, repeated until `PREADY`=1.
  - `PADDR`, `PWRITE`, `PWDATA` and `PSTRB` are stable from SETUP through the completing ACCESS cycle.
- Write data by state:
  - WR_RELOAD: `cfg_reload`.
  - WR_VALUE: `cfg_value`.
  - WR_CTRL: {0, `cfg_int_en`, 1'b0, 1'b0, 1'b1}, i.e. INT_EN, EXT_CLK=0, EXT_EN=0, TIMER_EN=1.
  - WR_STOP: CNTRL = 0.
- IDLE: `start`=1 and `abort`=0 latches the configuration, clears `expire_cnt`, and moves to WR_RELOAD. `start` in any other state is ignored.
- Sequence: WR_RELOAD → WR_VALUE → WR_CTRL → POLL_RD.
- POLL_RD reads INT and samples `PRDATA[0]` in the completing ACCESS cycle.
  - Bit = 0: go to POLL_GAP, wait `POLL_GAP` cycles, return to POLL_RD.
  - Bit = 1: pulse `irq`, increment `expire_cnt` (saturating), then proceed per Configuration.
- WR_STOP → END → IDLE. END lasts one cycle and pulses either `done` or `aborted`.
- Abort handling:
  - `abort` is latched into a sticky flag.
  - An in-flight APB transfer always completes; APB transfers are never truncated.
  - After any transfer completes, or from POLL_GAP immediately, a set flag forces WR_STOP.
  - The END cycle then pulses `aborted`, not `done`, and clears the flag.
- Expiry and abort resolved in the same POLL_RD completion: `irq` and the count update still occur, then WR_STOP, then `aborted`.
- With `cfg_int_en`=0 the timer never sets INT status. The run then ends only by `abort`; this is correct behaviour.

## Timing
- Reset values: `busy`=0, `done`=0, `aborted`=0, `irq`=0, `expire_cnt`=0, `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0, `PSTRB`=0. FSM state IDLE, abort flag clear.
- Reset mid-transfer drops `PSEL`/`PENABLE` on the next edge. No stop write is issued.
- All outputs are registered.
- `start` accepted at edge N: `busy`=1 and the first SETUP at N+1.
- With zero-wait `PREADY`, each transfer takes 2 cycles. The first POLL_RD SETUP occurs at N+7.
- Poll period with zero-wait slave: 2 + `POLL_GAP` cycles.
- `irq` is asserted in the cycle after the completing INT read.
- `done`/`aborted` is asserted in the END cycle. `busy` falls in the following cycle.

## Configuration
- Macro `TIMER_SEQ_PERIODIC_EN`.
- Defined (periodic mode): after an expiry, perform one write of `cfg_reload` to VALUE, then return to POLL_RD. The run continues until `abort`, and `done` never pulses.
- Undefined (one-shot mode): after an expiry, go to WR_STOP → END and pulse `done`.

## Test plan
- One-shot, zero-wait slave model: `cfg_reload`=5, `cfg_value`=3, `cfg_int_en`=1 → writes observed in order: 0x8 (5), 0x4 (3), 0x0 (0x9). Polls follow until INT=1; then exactly one `irq`, `expire_cnt`=1, CNTRL=0 write, one `done`.
- Wait states: slave holds `PREADY`=0 for 3 cycles on every transfer → `PADDR`/`PWDATA` stable throughout; sequence identical otherwise; no dropped or duplicated transfers.
- Abort during the WR_VALUE ACCESS phase → WR_VALUE completes, next transfer is CNTRL=0, then `aborted` pulses; `done` and `irq` stay 0.
- `start` while `busy` and `start`+`abort` together in IDLE → both ignored; no APB activity, `busy` stays 0 in the second case.
- Periodic build (`TIMER_SEQ_PERIODIC_EN`), slave forces 3 expiries → 3 `irq` pulses, VALUE rewritten with `cfg_reload` after each, `expire_cnt`=3; `abort` → CNTRL=0, `aborted`.
- `PRESET` asserted mid-poll → next cycle `PSEL`=0, `busy`=0, `expire_cnt`=0; a subsequent `start` runs normally.
